// File: rtl/seq_pkg.sv
// Shared constants and the speed-level to period mapping for the address sequencer.
package seq_pkg;

   localparam int LEVEL_W = 3;
   localparam int RATE_W  = 40;

   // Each level step is a factor of four; the top level runs at the base period.
   function automatic logic [RATE_W-1:0] period_of(input logic [LEVEL_W-1:0] level,
                                                   input logic [RATE_W-1:0]  base,
                                                   input int                 levels);
      int sh;
      sh = 2 * (levels - 1 - int'(level));
      return base << sh;
   endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw push-button conditioner: two-flop synchroniser, debounced level, press pulse.
module btn_cond #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             vld_p0;
   logic             vld_p1;
   logic             armed;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         armed   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         // stage p0/p1: synchroniser, with a valid bit marking real post-reset samples
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
         // debounce: a button held through reset stays ignored until seen released
         if (!armed) begin
            armed <= vld_p1 & ~sync_p1;
            cnt   <= '0;
         end else if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            level <= sync_p1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         // press pulse on the rising edge of the debounced level
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/addr_sequencer.sv
// Steps {bank, word} through NUM_BANKS banks at a button-selected rate, with pause and single-step.
module addr_sequencer
   import seq_pkg::*;
#(
   parameter int WORD_AW         = 7,
   parameter int NUM_BANKS       = 2,
   parameter int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   parameter int NUM_LEVELS      = 3,
   parameter int DEFAULT_LEVEL   = 1,
   parameter int BASE_PERIOD     = 25_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pause,
   input  logic                      speedup,
   input  logic                      speeddown,
   input  logic                      step,
   output logic [BANK_W+WORD_AW-1:0] addr,
   output logic                      advance,
   output logic                      paused,
   output logic [LEVEL_W-1:0]        speed_level
);

   localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
   localparam logic [WORD_AW-1:0] WORD_MAX  = '1;
   localparam logic [BANK_W-1:0]  BANK_MAX  = BANK_W'(NUM_BANKS - 1);

   logic                press_pause;
   logic                press_up;
   logic                press_down;
   logic                press_step;
   logic [RATE_W-1:0]   rate_cnt;
   logic [RATE_W-1:0]   period;
   logic [WORD_AW-1:0]  word;
   logic [BANK_W-1:0]   bank;
   logic                wrap;
   logic                do_adv;
   logic                lvl_chg;
   logic [LEVEL_W-1:0]  level_nxt;

   // Coincident up and down presses cancel; each direction saturates at its end of the ladder.
   function automatic logic [LEVEL_W-1:0] sat_level(input logic [LEVEL_W-1:0] lvl,
                                                    input logic               up,
                                                    input logic               dn);
      if (up && !dn && lvl != MAX_LEVEL)
         return lvl + LEVEL_W'(1);
      else if (dn && !up && lvl != '0)
         return lvl - LEVEL_W'(1);
      else
         return lvl;
   endfunction

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .clk(clk), .rst_n(rst_n), .btn(pause), .press(press_pause));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .rst_n(rst_n), .btn(speedup), .press(press_up));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .rst_n(rst_n), .btn(speeddown), .press(press_down));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk(clk), .rst_n(rst_n), .btn(step), .press(press_step));

   // Step and wrap both see the pre-toggle pause state, so a coincident pause never loses an advance.
   always_comb begin
      period    = period_of(speed_level, RATE_W'(BASE_PERIOD), NUM_LEVELS);
      wrap      = !paused && (rate_cnt == period - RATE_W'(1));
      do_adv    = wrap || (press_step && paused);
      level_nxt = sat_level(speed_level, press_up, press_down);
      lvl_chg   = (level_nxt != speed_level);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word        <= '0;
         bank        <= '0;
         advance     <= 1'b0;
         paused      <= 1'b0;
         speed_level <= LEVEL_W'(DEFAULT_LEVEL);
         rate_cnt    <= '0;
      end else begin
         advance     <= do_adv;
         speed_level <= level_nxt;
         if (press_pause)
            paused <= ~paused;

         if (press_pause || lvl_chg || wrap)
            rate_cnt <= '0;
         else if (!paused)
            rate_cnt <= rate_cnt + RATE_W'(1);

         if (do_adv) begin
            if (word == WORD_MAX) begin
               word <= '0;
               bank <= (bank == BANK_MAX) ? '0 : bank + BANK_W'(1);
            end else begin
               word <= word + WORD_AW'(1);
            end
         end
      end
   end

   assign addr = {bank, word};

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: main instance with three banks, plus a one-bank instance.
module tb_addr_sequencer;

   localparam int WAW = 2;
   localparam int AW  = 2 + WAW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rst2_n = 1'b0;
   logic          pause = 1'b0;
   logic          speedup = 1'b0;
   logic          speeddown = 1'b0;
   logic          step = 1'b0;
   logic          zero = 1'b0;
   logic [AW-1:0] addr;
   logic          advance;
   logic          paused;
   logic [2:0]    speed_level;
   logic [3:0]    addr2;
   logic          advance2;
   logic          paused2;
   logic [2:0]    speed_level2;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int adv_cnt = 0;
   int adv2_cnt = 0;
   int last_adv_cyc = 0;
   int prev_adv_cyc = 0;
   int sb_last = 0;
   int m_idx = 0;
   int exp_q[$];
   int exp2_q[$];

   addr_sequencer #(
      .WORD_AW(WAW), .NUM_BANKS(3), .NUM_LEVELS(3), .DEFAULT_LEVEL(1),
      .BASE_PERIOD(4), .DEBOUNCE_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pause(pause), .speedup(speedup),
      .speeddown(speeddown), .step(step), .addr(addr), .advance(advance),
      .paused(paused), .speed_level(speed_level)
   );

   addr_sequencer #(
      .WORD_AW(3), .NUM_BANKS(1), .NUM_LEVELS(1), .DEFAULT_LEVEL(0),
      .BASE_PERIOD(1), .DEBOUNCE_CYCLES(2)
   ) dut_b1 (
      .clk(clk), .rst_n(rst2_n), .pause(zero), .speedup(zero),
      .speeddown(zero), .step(zero), .addr(addr2), .advance(advance2),
      .paused(paused2), .speed_level(speed_level2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected address sequence: {bank,word} with 3 banks of 4 words is a linear index mod 12.
   task automatic push_model(input int n);
      for (int i = 0; i < n; i++) begin
         m_idx = (m_idx + 1) % 12;
         exp_q.push_back(m_idx);
      end
   endtask

   always @(negedge clk) begin
      if (advance) begin
         adv_cnt++;
         prev_adv_cyc = last_adv_cyc;
         last_adv_cyc = cyc;
         if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
         else begin
            sb_last = exp_q.pop_front();
            chk("sb_addr", addr, sb_last);
         end
      end
   end

   always @(negedge clk) begin
      if (advance2) begin
         adv2_cnt++;
         if (exp2_q.size() == 0) chk("b1_underflow", 0, 1);
         else chk("b1_addr", addr2, exp2_q.pop_front());
      end
   end

   task automatic drive(input int which, input logic v);
      case (which)
         0:       pause = v;
         1:       speedup = v;
         2:       speeddown = v;
         default: step = v;
      endcase
   endtask

   task automatic press(input int which);
      @(posedge clk); #1;
      drive(which, 1'b1);
      repeat (6) @(posedge clk);
      #1 drive(which, 1'b0);
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic wait_adv(input int n, input int budget);
      int target;
      int t;
      target = adv_cnt + n;
      t = 0;
      while (adv_cnt < target && t < budget) begin
         @(posedge clk);
         t++;
      end
      if (adv_cnt < target) chk("adv_timeout", adv_cnt, target);
      #1;
   endtask

   initial begin
      int rel_cyc;
      int s0;
      int a0;
      int n;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", addr, 0);
      chk("rst_adv", advance, 0);
      chk("rst_paused", paused, 0);
      chk("rst_level", speed_level, 1);
      push_model(400);
      rst_n = 1'b1;
      rel_cyc = cyc;

      // free run at level 1: one word every 16 cycles, bank wraps 2 -> 0
      wait_adv(13, 400);
      chk("run_timing", last_adv_cyc - rel_cyc, 13 * 16);
      chk("run_period", last_adv_cyc - prev_adv_cyc, 16);

      // speed ladder up, saturate, then down to level 0
      press(1);
      press(1);
      chk("lvl_up2", speed_level, 2);
      press(1);
      chk("lvl_sat_hi", speed_level, 2);
      wait_adv(3, 100);
      chk("period_lvl2", last_adv_cyc - prev_adv_cyc, 4);
      press(2);
      press(2);
      press(2);
      chk("lvl_sat_lo", speed_level, 0);
      wait_adv(3, 400);
      chk("period_lvl0", last_adv_cyc - prev_adv_cyc, 64);
      press(1);
      chk("lvl_back1", speed_level, 1);

      // simultaneous up/down cancels and leaves the rate counter alone
      wait_adv(1, 100);
      s0 = last_adv_cyc;
      speedup = 1'b1;
      speeddown = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      speedup = 1'b0;
      speeddown = 1'b0;
      wait_adv(2, 100);
      chk("cancel_lvl", speed_level, 1);
      chk("cancel_noclr", last_adv_cyc - s0, 32);

      // glitch, then held pause latency
      @(posedge clk); #1 pause = 1'b1;
      @(posedge clk); #1 pause = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("glitch", paused, 0);
      @(posedge clk); #1 pause = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("pause_early", paused, 0);
      @(posedge clk);
      #1 chk("pause_lat", paused, 1);
      repeat (4) @(posedge clk);
      #1 pause = 1'b0;
      a0 = adv_cnt;
      repeat (50) @(posedge clk);
      #1;
      chk("frz_cnt", adv_cnt, a0);
      chk("frz_addr", addr, sb_last);

      // single steps while paused
      s0 = sb_last;
      for (int i = 0; i < 3; i++) begin
         a0 = adv_cnt;
         press(3);
         chk("step_adv", adv_cnt - a0, 1);
      end
      chk("step_addr", addr, (s0 + 3) % 12);

      // reset mid-count with pause held, addr 7, level 2
      n = (7 - sb_last + 12) % 12;
      for (int i = 0; i < n; i++) press(3);
      press(1);
      chk("pre_rst_level", speed_level, 2);
      @(posedge clk); #1 pause = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("pre_rst_paused", paused, 0);
      chk("pre_rst_addr", addr, 7);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_adv", advance, 0);
      chk("mid_rst_paused", paused, 0);
      chk("mid_rst_level", speed_level, 1);
      exp_q.delete();
      m_idx = 0;
      push_model(400);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1 chk("held_no_toggle", paused, 0);
      pause = 1'b0;
      repeat (8) @(posedge clk);
      press(0);
      chk("repress_toggle", paused, 1);

      // single-bank instance: advance every cycle, 7 -> 0, bank bit stays 0
      for (int k = 1; k <= 16; k++) exp2_q.push_back(k % 8);
      @(posedge clk); #1 rst2_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      #1 rst2_n = 1'b0;
      chk("b1_cnt", adv2_cnt, 12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
